// File: rtl/digit_overlay.sv
// digit_overlay
//   Converts a binary value to decimal digits (serial double-dabble, one
//   bit per clock) and overlays them as a row of square glyph cells on a
//   VGA scan. New digits only reach the screen at frame start (0,0), so a
//   frame is never drawn with a mix of old and new digits.
//
// Ports
//   clock, reset          pixel clock, synchronous active-high reset
//   hdata, vdata          current scan coordinate
//   value, value_valid    binary value offer; value_ready high only in IDLE
//   blank_lead            suppress leading zero slots
//   glyph_digit/address   glyph ROM request (1 cycle after the coordinate)
//   glyph_data            ROM output, used as pixel colour
//   pixel_data/pixel_hit  overlay result (2 cycles after the coordinate)
//   overflow              displayed value was saturated to all nines

// One double-dabble correction step on a single BCD nibble.
module digit_overlay_dd (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module digit_overlay #(
  parameter int VGA_WIDTH   = 12,
  parameter int VALUE_WIDTH = 10,
  parameter int NUM_DIGITS  = 3,
  parameter int CELL_SIZE   = 40,
  parameter int ORIGIN_X    = 480,
  parameter int ORIGIN_Y    = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [VGA_WIDTH-1:0]   hdata,
  input  logic [VGA_WIDTH-1:0]   vdata,
  input  logic [VALUE_WIDTH-1:0] value,
  input  logic                   value_valid,
  output logic                   value_ready,
  input  logic                   blank_lead,
  output logic [3:0]             glyph_digit,
  output logic [15:0]            glyph_address,
  input  logic [31:0]            glyph_data,
  output logic [31:0]            pixel_data,
  output logic                   pixel_hit,
  output logic                   overflow
);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

  // Scratch must hold every decimal digit of the largest input, and at
  // least NUM_DIGITS nibbles so every slot has a source.
  localparam int BCD_MIN = VALUE_WIDTH / 3 + 1;
  localparam int BCD_N   = (BCD_MIN > NUM_DIGITS) ? BCD_MIN : NUM_DIGITS;
  localparam int CNT_W   = $clog2(VALUE_WIDTH + 1);
  localparam int SLOT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [63:0] LIMIT = pow10(NUM_DIGITS);
  localparam logic [31:0] X0 = ORIGIN_X;
  localparam logic [31:0] Y0 = ORIGIN_Y;
  localparam logic [31:0] X1 = ORIGIN_X + NUM_DIGITS * CELL_SIZE;
  localparam logic [31:0] Y1 = ORIGIN_Y + CELL_SIZE;
  localparam logic [31:0] CS = CELL_SIZE;

  typedef enum logic [1:0] {IDLE, SHIFT, PEND} state_t;

  state_t                          state, state_nxt;
  logic [VALUE_WIDTH-1:0]          bin_sr;
  logic [BCD_N-1:0][3:0]           bcd, bcd_adj;
  logic [CNT_W-1:0]                step;
  logic                            ovf_pend;
  logic [NUM_DIGITS-1:0][3:0]      pend;   // indexed by slot, slot 0 = MSD
  logic [NUM_DIGITS-1:0][3:0]      disp;
  logic                            disp_ovf;
  logic                            frame_start;

  // ---------------- conversion ----------------
  for (genvar i = 0; i < BCD_N; i++) begin : g_dd
    digit_overlay_dd u_dd (.d(bcd[i]), .q(bcd_adj[i]));
  end

  assign frame_start = (hdata == '0) && (vdata == '0);

  always_comb begin
    state_nxt   = state;
    value_ready = 1'b0;
    case (state)
      IDLE: begin
        value_ready = 1'b1;
        if (value_valid) state_nxt = SHIFT;
      end
      SHIFT: if (step == CNT_W'(VALUE_WIDTH - 1)) state_nxt = PEND;
      PEND:  if (frame_start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pend = '0;
    for (int s = 0; s < NUM_DIGITS; s++)
      pend[s] = ovf_pend ? 4'd9 : bcd[NUM_DIGITS-1-s];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd      <= '0;
      step     <= '0;
      ovf_pend <= 1'b0;
      disp     <= '0;
      disp_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (value_valid) begin
          bin_sr   <= value;
          bcd      <= '0;
          step     <= '0;
          ovf_pend <= {{(64-VALUE_WIDTH){1'b0}}, value} >= LIMIT;
        end
        SHIFT: begin
          // Correct nibbles first, then shift the next binary bit in.
          {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
          step          <= step + 1'b1;
        end
        PEND: if (frame_start) begin
          disp     <= pend;
          disp_ovf <= ovf_pend;
        end
        default: ;
      endcase
    end
  end

  assign overflow = disp_ovf;

  // ---------------- overlay pipeline ----------------
  logic [31:0]             hx, vy, dx, lx, ly;
  logic                    in_region;
  logic [SLOT_W-1:0]       slot;
  logic [15:0]             addr;
  logic [NUM_DIGITS-1:0]   blank;
  logic                    zrun;
  logic                    hit_s1;

  always_comb begin
    hx        = 32'(hdata);
    vy        = 32'(vdata);
    // Region test before any subtraction, so coordinates left of or
    // above the origin never wrap into the region.
    in_region = (hx >= X0) && (hx < X1) && (vy >= Y0) && (vy < Y1);
    dx        = hx - X0;
    ly        = vy - Y0;
    slot      = '0;
    for (int k = 1; k < NUM_DIGITS; k++)
      if (dx >= 32'(k) * CS) slot = SLOT_W'(k);
    lx        = dx - 32'(slot) * CS;
    addr      = 16'(ly * CS + lx);
  end

  // A slot blanks while it and every more significant slot is zero.
  always_comb begin
    zrun  = 1'b1;
    blank = '0;
    for (int s = 0; s < NUM_DIGITS; s++) begin
      zrun     = zrun && (disp[s] == 4'd0);
      blank[s] = blank_lead && !disp_ovf && zrun && (s != NUM_DIGITS - 1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      glyph_digit   <= '0;
      glyph_address <= '0;
      hit_s1        <= 1'b0;
      pixel_hit     <= 1'b0;
      pixel_data    <= '0;
    end else begin
      glyph_digit   <= in_region ? disp[slot] : 4'd0;
      glyph_address <= in_region ? addr : 16'd0;
      hit_s1        <= in_region && !blank[slot];
      pixel_hit     <= hit_s1;
      pixel_data    <= hit_s1 ? glyph_data : 32'd0;
    end
  end

endmodule

// File: tb/tb_digit_overlay.sv
module tb_digit_overlay;
  localparam int VW = 10, N = 3, CELL = 40, OX = 480, OY = 0;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] hdata, vdata;
  logic [9:0]  value;
  logic        value_valid, value_ready, blank_lead;
  logic [3:0]  glyph_digit;
  logic [15:0] glyph_address;
  logic [31:0] glyph_data, pixel_data;
  logic        pixel_hit, overflow;

  digit_overlay dut (
    .clock(clock), .reset(reset), .hdata(hdata), .vdata(vdata),
    .value(value), .value_valid(value_valid), .value_ready(value_ready),
    .blank_lead(blank_lead), .glyph_digit(glyph_digit),
    .glyph_address(glyph_address), .glyph_data(glyph_data),
    .pixel_data(pixel_data), .pixel_hit(pixel_hit), .overflow(overflow)
  );

  always #5 clock = ~clock;

  // Glyph ROM stand-in: content encodes digit and address so a wrong
  // lookup shows up in pixel_data.
  function automatic logic [31:0] rom(input logic [3:0] d, input logic [15:0] a);
    return {4'hA, d, 8'h5C, a};
  endfunction
  assign glyph_data = rom(glyph_digit, glyph_address);

  int n_checks = 0, n_errors = 0;
  int p10[0:5] = '{1, 10, 100, 1000, 10000, 100000};

  // Reference model: the number currently on screen.
  int   m_val = 0;
  logic m_ovf = 1'b0;
  logic m_blank = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic void exp_px(input int h, input int v, output logic hit,
                                 output logic [3:0] dg, output logic [15:0] ad);
    int s;
    logic in;
    in  = (h >= OX) && (h < OX + N*CELL) && (v >= OY) && (v < OY + CELL);
    s   = in ? (h - OX) / CELL : 0;
    dg  = !in ? 4'd0 : m_ovf ? 4'd9 : 4'((m_val / p10[N-1-s]) % 10);
    ad  = in ? 16'((v - OY) * CELL + (h - OX) % CELL) : 16'd0;
    hit = in && !(m_blank && !m_ovf && s < N-1 && m_val < p10[N-1-s]);
  endfunction

  // Streaming scan: one coordinate per clock, stage-1 outputs checked
  // against this coordinate, stage-2 outputs against the previous one.
  int   ph, pv;
  logic pvalid;

  task automatic scan_begin();
    pvalid = 1'b0;
  endtask

  task automatic scan_pt(input int h, input int v);
    logic hit;
    logic [3:0] dg;
    logic [15:0] ad;
    hdata = 12'(h);
    vdata = 12'(v);
    tick();
    exp_px(h, v, hit, dg, ad);
    chk($sformatf("glyph_digit(%0d,%0d)", h, v), 32'(glyph_digit), 32'(dg));
    chk($sformatf("glyph_address(%0d,%0d)", h, v), 32'(glyph_address), 32'(ad));
    if (pvalid) begin
      exp_px(ph, pv, hit, dg, ad);
      chk($sformatf("pixel_hit(%0d,%0d)", ph, pv), 32'(pixel_hit), 32'(hit));
      chk($sformatf("pixel_data(%0d,%0d)", ph, pv), pixel_data, hit ? rom(dg, ad) : 32'd0);
    end
    ph = h; pv = v; pvalid = 1'b1;
  endtask

  task automatic scan_row(input int v, input int h0, input int h1);
    scan_begin();
    for (int h = h0; h <= h1; h++) scan_pt(h, v);
  endtask

  task automatic scan_rand(input int n);
    scan_begin();
    for (int i = 0; i < n; i++) scan_pt($urandom_range(470, 610), $urandom_range(0, 45));
  endtask

  task automatic park();
    hdata = 12'd1000;
    vdata = 12'd1000;
  endtask

  task automatic load(input int v);
    int t = 0;
    while (!value_ready && t < 100) begin tick(); t++; end
    chk("load_ready_timeout", 32'(t < 100), 32'd1);
    value = 10'(v);
    value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
  endtask

  // Hold frame start until the pending value commits; returns the number
  // of clocks that took.
  task automatic commit(input int v, output int t);
    hdata = 12'd0;
    vdata = 12'd0;
    t = 0;
    while (!value_ready && t < 100) begin tick(); t++; end
    chk("commit_timeout", 32'(t < 100), 32'd1);
    park();
    m_ovf = (v >= p10[N]);
    m_val = m_ovf ? 0 : v;
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    int t;
    reset = 1'b1; value = '0; value_valid = 1'b0; blank_lead = 1'b0;
    park();
    tick(); tick();
    chk("rst_value_ready", 32'(value_ready), 32'd1);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_glyph_digit", 32'(glyph_digit), 32'd0);
    chk("rst_glyph_address", 32'(glyph_address), 32'd0);
    chk("rst_pixel_hit", 32'(pixel_hit), 32'd0);
    chk("rst_pixel_data", pixel_data, 32'd0);
    reset = 1'b0;
    tick();
    scan_row(5, 478, 482);           // reset digits show as 000

    // 347: exactly VW shift cycles, commit on entry to PEND at (0,0).
    load(347);
    chk("busy_after_accept", 32'(value_ready), 32'd0);
    commit(347, t);
    chk("ready_latency", 32'(t), 32'(VW + 1));
    scan_begin(); scan_pt(530, 5); scan_pt(530, 5);
    scan_row(20, 475, 605);

    // Overflow saturates, then clears.
    load(1000); commit(1000, t);
    scan_row(0, 478, 602);
    load(12); commit(12, t);
    scan_row(39, 478, 602);

    // Leading-zero suppression.
    blank_lead = 1'b1; m_blank = 1'b1;
    load(5); commit(5, t);
    scan_row(10, 478, 601);
    load(0); commit(0, t);
    scan_row(10, 478, 601);
    load(1023); commit(1023, t);     // blanking ignored while overflowed
    scan_row(10, 478, 601);
    blank_lead = 1'b0; m_blank = 1'b0;

    // value_valid during conversion is ignored until IDLE returns; the
    // display holds until frame start.
    load(347);
    value = 10'd999; value_valid = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("busy_held_valid", 32'(value_ready), 32'd0);
    chk("no_early_commit_ovf", 32'(overflow), 32'(m_ovf));
    hdata = 12'd0; vdata = 12'd0;
    tick();
    chk("ready_after_commit", 32'(value_ready), 32'd1);
    m_ovf = 1'b0; m_val = 347;
    park();
    tick();
    chk("accept_999_first_idle", 32'(value_ready), 32'd0);
    value_valid = 1'b0;
    scan_row(15, 478, 602);          // still 347 while 999 pends
    commit(999, t);
    scan_row(15, 478, 602);

    // Reset on SHIFT cycle 4 aborts the conversion.
    load(347);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_ready", 32'(value_ready), 32'd1);
    chk("abort_overflow", 32'(overflow), 32'd0);
    m_val = 0; m_ovf = 1'b0;
    hdata = 12'd0; vdata = 12'd0;
    tick(); tick();
    park();
    chk("abort_stays_idle", 32'(value_ready), 32'd1);
    scan_row(5, 478, 602);

    // Region boundaries.
    load(678); commit(678, t);
    scan_begin();
    scan_pt(479, 10); scan_pt(600, 10); scan_pt(500, 40); scan_pt(599, 39);
    scan_pt(480, 0); scan_pt(599, 0); scan_pt(480, 39); scan_pt(600, 39);

    // Randomized conversions, scanning both before and after commit.
    for (int it = 0; it < 12; it++) begin
      int v = $urandom_range(0, 1100);
      blank_lead = 1'($urandom_range(0, 1));
      m_blank = blank_lead;
      load(v);
      scan_rand(25);                 // old value remains visible
      commit(v, t);
      scan_rand(50);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/digit_overlay.md
DIGIT_OVERLAY -- requirements
Module: digit_overlay

Interface
REQ-001 SHALL have parameter VGA_WIDTH, default 12, width of hdata/vdata.
REQ-002 SHALL have parameter VALUE_WIDTH, default 10, width of the binary input value.
REQ-003 SHALL have parameter NUM_DIGITS, default 3, number of decimal digit slots (1..5).
REQ-004 SHALL have parameter CELL_SIZE, default 40, square glyph cell edge in pixels.
REQ-005 SHALL have parameters ORIGIN_X, default 480, and ORIGIN_Y, default 0, giving the top-left pixel of slot 0.
REQ-006 SHALL use one clock and a synchronous, active-high reset.
REQ-007 clock  in  1  pixel clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous active-high reset.
REQ-009 hdata, vdata  in  VGA_WIDTH  current scan coordinates.
REQ-010 value  in  VALUE_WIDTH  binary number to display.
REQ-011 value_valid  in  1  value offered; value_ready  out  1  block can accept a value.
REQ-012 blank_lead  in  1  enables leading-zero suppression.
REQ-013 glyph_digit  out  4, glyph_address  out  16  glyph ROM read request; glyph_data  in  32  ROM output, one-cycle read latency.
REQ-014 pixel_data  out  32, pixel_hit  out  1, overflow  out  1.

Function
REQ-015 FSM states SHALL be IDLE, SHIFT, PEND; value_ready SHALL be 1 only in IDLE.
REQ-016 Transfer SHALL occur when value_valid && value_ready; the block latches value, clears BCD scratch, sets shift count 0, and goes to SHIFT.
REQ-017 value_valid outside IDLE SHALL be ignored; nothing latched.
REQ-018 SHIFT SHALL perform one double-dabble step per cycle: add 3 to each scratch nibble >= 5, then shift left one bit, MSB first. After exactly VALUE_WIDTH steps it goes to PEND.
REQ-019 Overflow check at transfer: value >= 10^NUM_DIGITS sets the pending overflow flag. The pending digits then become all 9 (saturation) instead of the conversion result.
REQ-020 PEND SHALL commit pending digits and the overflow flag to the display registers on the first cycle with hdata==0 && vdata==0, then return to IDLE. If that condition is already true on entry, the commit occurs that cycle. Display never changes mid-frame.
REQ-021 Display region SHALL be hdata in [ORIGIN_X, ORIGIN_X+NUM_DIGITS*CELL_SIZE) and vdata in [ORIGIN_Y, ORIGIN_Y+CELL_SIZE). Slot = (hdata-ORIGIN_X)/CELL_SIZE, slot 0 most significant. lx, ly = offsets within the cell.
REQ-022 Stage 1, registered one cycle after the coordinate: glyph_digit = displayed digit of the slot, glyph_address = ly*CELL_SIZE+lx, and internal hit = inside region and not blanked. Outside the region: glyph_address=0, glyph_digit=0.
REQ-023 Stage 2, registered two cycles after the coordinate: pixel_hit = delayed hit; pixel_data = glyph_data if hit, else 0. Total latency SHALL be exactly 2 cycles.
REQ-024 With blank_lead=1, a slot SHALL be blanked when it and all more-significant slots hold 0. The least significant slot is never blanked. Blanking is ignored while overflow=1.
REQ-025 Arithmetic for address and slot SHALL be unsigned without wrap. Coordinates below the origin SHALL count as outside the region, with no underflow.

Reset
REQ-026 Reset SHALL force IDLE, value_ready=1, all displayed and pending digits 0, overflow=0, glyph_digit=0, glyph_address=0, pixel_hit=0, pixel_data=0.
REQ-027 Reset in SHIFT or PEND SHALL abort the conversion; the aborted value is never displayed.

Verification
REQ-028 value=347 accepted -> value_ready=0 for 10 SHIFT cycles, then PEND. After the frame-start commit, coordinate (530,5) -> glyph_digit=4, glyph_address=210 one cycle later, pixel_data=glyph_data and pixel_hit=1 two cycles later.
REQ-029 value=1000 -> overflow=1 after commit, digits 9,9,9. Then value=12 -> overflow=0, digits 0,1,2.
REQ-030 blank_lead=1, value=5 -> pixel_hit=0 across x 480..559, pixel_hit=1 at glyph pixels in 560..599. value=0 -> only slot 2 shown, digit 0.
REQ-031 value_valid held high during SHIFT with value=999 -> not accepted; accepted on the first IDLE cycle after the previous commit.
REQ-032 reset asserted on SHIFT cycle 4 of value=347 -> next cycle IDLE, value_ready=1. After the next frame start all slots still display 0.
REQ-033 Boundary scan: hdata=479 and hdata=600 at vdata=10, and vdata=40 at hdata=500 -> pixel_hit=0, pixel_data=0. hdata=599, vdata=39 -> glyph_address=1599.
